// File: rtl/dmem_responder.sv
// Word-addressed data RAM behind a valid/ready request/response pair, with a
// fixed access latency of LAT cycles and a misaligned-address error flag.
module dmem_responder #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int LAT        = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_data,
  output logic                  resp_err,
  output logic [1:0]            dbg_state_o
);

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; a response transfers on a rising edge where
  // resp_valid and resp_ready are both high. Only one transaction is ever in
  // flight, so req_ready is low from the accept edge until the response leaves.

  localparam int         IDX_W    = DM_ADDRESS - 2;
  localparam int         WORDS    = 2 ** IDX_W;
  localparam bit         LAT_ONE  = (LAT == 1);
  localparam logic [3:0] CNT_INIT = (LAT > 1) ? 4'(LAT - 2) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    write_q, write_d;
  logic [DM_ADDRESS-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [DATA_W-1:0]       mem_q [WORDS];

  logic                    accept;
  logic                    commit;
  logic                    c_write;
  logic [DM_ADDRESS-1:0]   c_addr;
  logic [DATA_W-1:0]       c_wdata;
  logic [IDX_W-1:0]        c_idx;
  logic                    c_mis;
  logic                    mem_we;

  assign accept = req_valid && (state_q == S_IDLE);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (mem_we) begin
        mem_q[c_idx] <= c_wdata;
      end
    end
  end

  // ---------------------------------------------------------- next-state comb
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LAT_ONE) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The access commits on the edge that enters RESP. With LAT=1 that is the
  // accept edge itself, so the operands come straight from the request port.
  always_comb begin
    commit  = (LAT_ONE && accept) || ((state_q == S_WAIT) && (cnt_q == 4'd0));
    c_write = (state_q == S_IDLE) ? req_write : write_q;
    c_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    c_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
    c_idx   = c_addr[DM_ADDRESS-1:2];
    c_mis   = |c_addr[1:0];
    mem_we  = commit && c_write && !c_mis;
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (commit) begin
      rdata_d = (c_write || c_mis) ? '0 : mem_q[c_idx];
      err_d   = c_mis;
    end else if ((state_q == S_RESP) && resp_ready) begin
      rdata_d = '0;
      err_d   = 1'b0;
    end
  end

  // ------------------------------------------------------------- output comb
  always_comb begin
    req_ready   = (state_q == S_IDLE);
    resp_valid  = (state_q == S_RESP);
    resp_data   = rdata_q;
    resp_err    = err_q;
    dbg_state_o = state_q;
  end

endmodule
